// File: rtl/ring_johnson_monitor.sv
// Registered checker/decoder for a ring or Johnson shift counter.
// It classifies each sample, tracks single-step advances, flags illegal or skipped states and drives one hex digit.
module ring_johnson_monitor #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s,
    input  logic [0:N-1] q,
    input  logic         clr,
    output logic [3:0]   idx,
    output logic         valid,
    output logic [7:0]   step_cnt,
    output logic         err_illegal,
    output logic         err_skip,
    output logic [6:0]   hex0
);

    localparam logic [3:0] RING_LAST = 4'(N - 1);
    localparam logic [3:0] JOHN_LAST = 4'(2 * N - 1);

    // One-hot ring state p, bit 0 is the shift-in end.
    function automatic logic [0:N-1] ring_pattern(input int p);
        logic [0:N-1] v;
        for (int j = 0; j < N; j++) begin
            v[j] = (j == p);
        end
        return v;
    endfunction

    // Johnson state i: i ones filling from bit 0, then zeros filling from bit 0.
    function automatic logic [0:N-1] johnson_pattern(input int i);
        logic [0:N-1] v;
        for (int j = 0; j < N; j++) begin
            v[j] = (i <= N) ? (j < i) : (j >= i - N);
        end
        return v;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic       cur_legal;
    logic       cur_illegal;
    logic [3:0] cur_idx;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cur_legal = 1'b0;
        cur_idx   = '0;
        if (s) begin
            for (int i = 0; i < 2 * N; i++) begin
                if (q == johnson_pattern(i)) begin
                    cur_legal = 1'b1;
                    cur_idx   = 4'(i);
                end
            end
        end else begin
            for (int p = 0; p < N; p++) begin
                if (q == ring_pattern(p)) begin
                    cur_legal = 1'b1;
                    cur_idx   = 4'(p);
                end
            end
        end
        // All-zero in ring mode is idle: neither legal nor an error.
        cur_illegal = !cur_legal && (s || (q != '0));
    end

    // idx_q/valid_q double as the previous-sample index and legality.
    logic [3:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic [7:0] step_cnt_q, step_cnt_d;
    logic       err_illegal_q, err_illegal_d;
    logic       err_skip_q, err_skip_d;
    logic [6:0] hex0_q, hex0_d;
    logic       prev_s_q, prev_s_d;

    logic       step_check;
    logic [3:0] next_idx;

    always_comb begin
        idx_d         = cur_legal ? cur_idx : '0;
        valid_d       = cur_legal;
        prev_s_d      = s;
        hex0_d        = cur_legal ? seg_decode(cur_idx) : 7'h7F;
        step_cnt_d    = step_cnt_q;
        err_illegal_d = err_illegal_q | cur_illegal;
        err_skip_d    = err_skip_q;

        next_idx   = (idx_q == (s ? JOHN_LAST : RING_LAST)) ? 4'd0 : idx_q + 4'd1;
        step_check = cur_legal && valid_q && (prev_s_q == s);

        if (step_check && (cur_idx != idx_q)) begin
            if (cur_idx == next_idx) begin
                step_cnt_d = step_cnt_q + 8'd1;
            end else begin
                err_skip_d = 1'b1;
            end
        end

        if (clr) begin
            step_cnt_d    = '0;
            err_illegal_d = 1'b0;
            err_skip_d    = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q         <= '0;
            valid_q       <= 1'b0;
            step_cnt_q    <= '0;
            err_illegal_q <= 1'b0;
            err_skip_q    <= 1'b0;
            hex0_q        <= 7'h7F;
            prev_s_q      <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            valid_q       <= valid_d;
            step_cnt_q    <= step_cnt_d;
            err_illegal_q <= err_illegal_d;
            err_skip_q    <= err_skip_d;
            hex0_q        <= hex0_d;
            prev_s_q      <= prev_s_d;
        end
    end

    assign idx         = idx_q;
    assign valid       = valid_q;
    assign step_cnt    = step_cnt_q;
    assign err_illegal = err_illegal_q;
    assign err_skip    = err_skip_q;
    assign hex0        = hex0_q;

endmodule

// File: tb/tb_ring_johnson_monitor.sv
// Randomized bench for ring_johnson_monitor: a state-table model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_ring_johnson_monitor;

    localparam int N = 5;
    typedef logic [N-1:0] pat_t;  // MSB is counter bit 0

    logic         clk;
    logic         reset;
    logic         s;
    logic [0:N-1] q;
    logic         clr;
    logic [3:0]   idx;
    logic         valid;
    logic [7:0]   step_cnt;
    logic         err_illegal;
    logic         err_skip;
    logic [6:0]   hex0;

    ring_johnson_monitor #(.N(N)) dut (
        .clk(clk), .reset(reset), .s(s), .q(q), .clr(clr),
        .idx(idx), .valid(valid), .step_cnt(step_cnt),
        .err_illegal(err_illegal), .err_skip(err_skip), .hex0(hex0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic pat_t ring_pat(input int p);
        return pat_t'(1 << (N - 1 - p));
    endfunction

    function automatic pat_t john_pat(input int i);
        if (i <= N) return pat_t'(((1 << i) - 1) << (N - i));
        return pat_t'((1 << (2 * N - i)) - 1);
    endfunction

    function automatic pat_t pat_of(input bit mode, input int i);
        return mode ? john_pat(i) : ring_pat(i);
    endfunction

    // Model: look the sample up in the table of legal states for the mode.
    int m_idx, m_cnt;
    bit m_valid, m_ill, m_skip, m_prev_s;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_idx = 0; m_cnt = 0; m_valid = 0; m_ill = 0; m_skip = 0; m_prev_s = 0;
        end else begin
            pat_t v;
            int   m, ix;
            bit   legal;
            v = q;
            m = s ? 2 * N : N;
            legal = 0; ix = 0;
            for (int i = 0; i < m; i++) begin
                if (v == pat_of(s, i)) begin legal = 1; ix = i; end
            end
            if (!legal && (s || v != 0)) m_ill = 1;
            if (legal && m_valid && m_prev_s == s && ix != m_idx) begin
                if (ix == (m_idx + 1) % m) m_cnt = (m_cnt + 1) % 256;
                else m_skip = 1;
            end
            if (clr) begin m_cnt = 0; m_ill = 0; m_skip = 0; end
            m_idx    = legal ? ix : 0;
            m_valid  = legal;
            m_prev_s = s;
        end
    end

    always @(negedge clk) begin
        check("valid", valid, m_valid);
        if (m_valid) check("idx", idx, m_idx);
        check("step_cnt", step_cnt, m_cnt);
        check("err_illegal", err_illegal, m_ill);
        check("err_skip", err_skip, m_skip);
        check("hex0", hex0, m_valid ? seg_tbl[m_idx] : 7'h7F);
    end

    pat_t qv;

    task automatic drive(input bit s_i, input pat_t q_i, input bit clr_i);
        @(negedge clk);
        s = s_i; qv = q_i; q = q_i; clr = clr_i;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_idx"}, idx, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_cnt"}, step_cnt, 0);
        check({tag, "_ill"}, err_illegal, 0);
        check({tag, "_skip"}, err_skip, 0);
        check({tag, "_hex"}, hex0, 7'h7F);
    endtask

    task automatic random_phase(input int cycles);
        bit rs;
        rs = s;
        for (int n = 0; n < cycles; n++) begin
            int   r, m;
            pat_t nq;
            r  = $urandom_range(0, 99);
            nq = qv;
            if (r < 8) rs = ~rs;
            m = rs ? 2 * N : N;
            if (r >= 8 && r < 55)
                nq = pat_of(rs, m_valid ? (m_idx + 1) % m : $urandom_range(0, m - 1));
            else if (r >= 70 && r < 82) nq = pat_of(rs, $urandom_range(0, m - 1));
            else if (r >= 82 && r < 92) nq = pat_t'($urandom);
            else if (r >= 92) nq = '0;
            drive(rs, nq, $urandom_range(0, 29) == 0);
        end
    endtask

    pat_t john_seq [11] = '{5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111,
                           5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000};
    int   john_idx [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};

    initial begin
        reset = 1'b0; s = 1'b0; clr = 1'b0; qv = '0; q = '0;
        for (int i = 0; i < 3; i++) drive(1'($urandom), pat_t'($urandom), 1'b0);
        check_reset_vals("rst");

        @(negedge clk);
        reset = 1'b1; s = 1'b0; qv = 5'b10000; q = qv; clr = 1'b0;
        @(posedge clk); #1;
        check("first_idx", idx, 0);
        check("first_valid", valid, 1);
        check("first_hex", hex0, 7'h40);
        check("first_cnt", step_cnt, 0);

        drive(0, 5'b01000, 0); drive(0, 5'b00100, 0); drive(0, 5'b00010, 0);
        drive(0, 5'b00001, 0); drive(0, 5'b10000, 0);
        check("ring_cnt", step_cnt, 5);
        check("ring_idx", idx, 0);
        check("ring_err", {err_illegal, err_skip}, 0);

        for (int i = 0; i < 11; i++) begin
            drive(1, john_seq[i], i == 0);
            check("john_idx", idx, john_idx[i]);
        end
        check("john_cnt", step_cnt, 10);
        check("john_err", {err_illegal, err_skip}, 0);
        check("john_hex0", hex0, 7'h40);

        drive(0, 5'b11000, 0);
        check("ill_flag", err_illegal, 1);
        check("ill_valid", valid, 0);
        check("ill_hex", hex0, 7'h7F);
        drive(0, 5'b00100, 0);
        check("ill_nocheck", err_skip, 0);
        drive(0, 5'b00001, 0);
        check("skip_flag", err_skip, 1);
        check("skip_cnt", step_cnt, 10);

        drive(0, 5'b00100, 1);
        check("clr_cnt", step_cnt, 0);
        check("clr_flags", {err_illegal, err_skip}, 0);
        for (int i = 0; i < 3; i++) drive(0, 5'b00100, 0);
        check("hold_cnt", step_cnt, 0);
        check("hold_err", {err_illegal, err_skip}, 0);
        drive(0, 5'b00000, 0);
        check("idle_hex", hex0, 7'h7F);
        drive(0, 5'b00010, 0);
        check("load_err", {err_illegal, err_skip}, 0);
        check("load_idx", idx, 3);

        for (int i = 0; i < 256; i++) drive(0, ring_pat((4 + i) % N), 0);
        check("wrap_cnt", step_cnt, 0);
        check("wrap_err", {err_illegal, err_skip}, 0);
        drive(0, 5'b10000, 0); drive(0, 5'b01000, 0); drive(0, 5'b00100, 0);
        check("pre_mode_cnt", step_cnt, 3);
        drive(1, 5'b00100, 0);
        check("mode_ill", err_illegal, 1);
        check("mode_skip", err_skip, 0);

        random_phase(500);

        #3 reset = 1'b0;
        #1 check_reset_vals("async");
        drive(0, 5'b10000, 0);
        drive(0, 5'b00000, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 5'b00001, 0);
        drive(0, 5'b10000, 0);
        check("post_rst_cnt", step_cnt, 1);
        check("post_rst_err", {err_illegal, err_skip}, 0);

        random_phase(500);

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
